rr_arbiter_n: RTL and testbench

//   N-channel round-robin arbiter that drains per-channel FIFOs into one shared output mux.
//   - Decides which FIFO to pop each cycle.
//   - Registers the mux select and valid one cycle later, in step with the FIFO's registered read data.
//   - Supersedes the 2-channel arbiter: adds a configurable channel count, programmable burst length
//     per grant, and downstream back-pressure (stall).
//

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_priority_pick.sv | 36 +++
 rtl/rr_arbiter_n.sv | 119 +++++++++++
 tb/tb_rr_arbiter_n.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-channel round-robin FIFO drain arbiter.
// State encodings, burst-length normalisation and one-hot to index encoding.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // A programmed burst length of zero still grants one pop.
    function automatic int eff_burst(input int len);
        return (len == 0) ? 1 : len;
    endfunction

    function automatic int onehot_to_idx(input logic [63:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin winner search: first set request strictly after last_ch, circularly.
// The request vector is doubled so the wrap-around becomes a plain masked first-one search.
module rr_priority_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_ch,
    output logic              any_req,
    output logic [SEL_W-1:0]  winner
);

    logic [2*NUM_CH-1:0] dbl;
    logic [2*NUM_CH-1:0] mask;
    logic [2*NUM_CH-1:0] masked;
    logic                found;

    always_comb begin
        dbl     = {req, req};
        mask    = '0;
        winner  = '0;
        found   = 1'b0;
        any_req = |req;
        for (int i = 0; i < 2*NUM_CH; i++) begin
            mask[i] = (i > int'(last_ch)) && (i <= int'(last_ch) + NUM_CH);
        end
        masked = dbl & mask;
        for (int i = 0; i < 2*NUM_CH; i++) begin
            if (!found && masked[i]) begin
                found  = 1'b1;
                winner = SEL_W'((i >= NUM_CH) ? (i - NUM_CH) : i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-channel round-robin arbiter draining per-channel FIFOs with bursts and back-pressure.
// Pop is combinational; mux select and valid are registered to line up with FIFO read data.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ARB_IDLE  | no grant in progress; arbitrate each unstalled cycle
//   ARB_BURST | last_ch owns the output until cnt reaches blen or it drains
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int SEL_W   = $clog2(NUM_CH),
    parameter int BURST_W = 3
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [NUM_CH-1:0]  req,
    input  logic               stall,
    input  logic [BURST_W-1:0] burst_len,
    output logic [NUM_CH-1:0]  pop,
    output logic [SEL_W-1:0]   port_mux,
    output logic               valid_mux
);

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [BURST_W-1:0] blen_q, blen_d;
    logic [SEL_W-1:0]   port_q, port_d;
    logic               valid_q, valid_d;

    logic [NUM_CH-1:0]  pop_c;
    logic               any_req;
    logic [SEL_W-1:0]   winner;
    logic               arbitrate;
    logic [BURST_W-1:0] blen_new;
    logic [BURST_W-1:0] cnt_inc;

    rr_priority_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req     (req),
        .last_ch (last_q),
        .any_req (any_req),
        .winner  (winner)
    );

    assign blen_new = BURST_W'(eff_burst(32'(burst_len)));
    assign cnt_inc  = cnt_q + BURST_W'(1);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        blen_d    = blen_q;
        pop_c     = '0;
        arbitrate = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                arbitrate = !stall;
            end
            ARB_BURST: begin
                if (!stall) begin
                    if (req[last_q]) begin
                        pop_c[last_q] = 1'b1;
                        cnt_d         = cnt_inc;
                        if (cnt_inc == blen_q) state_d = ARB_IDLE;
                    end else begin
                        // Owner drained: hand over this cycle, owner ends up lowest priority.
                        arbitrate = 1'b1;
                        state_d   = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (arbitrate && any_req) begin
            pop_c         = '0;
            pop_c[winner] = 1'b1;
            last_d        = winner;
            cnt_d         = BURST_W'(1);
            blen_d        = blen_new;
            state_d       = (blen_new > BURST_W'(1)) ? ARB_BURST : ARB_IDLE;
        end
    end

    // Pop must read zero for the whole time reset is held, not just after the next edge.
    assign pop = reset_L ? pop_c : '0;

    always_comb begin
        valid_d = |pop_c;
        port_d  = (|pop_c) ? SEL_W'(onehot_to_idx(64'(pop_c))) : port_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ARB_IDLE;
            last_q  <= SEL_W'(NUM_CH - 1);
            cnt_q   <= '0;
            blen_q  <= BURST_W'(1);
            port_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            blen_q  <= blen_d;
            port_q  <= port_d;
            valid_q <= valid_d;
        end
    end

    assign port_mux  = port_q;
    assign valid_mux = valid_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n (NUM_CH=4, BURST_W=3): behavioural model feeding a
// scoreboard of registered outputs, directed pop sequences, and random invariant checks.
module tb_rr_arbiter_n;

    localparam int NUM_CH  = 4;
    localparam int SEL_W   = 2;
    localparam int BURST_W = 3;
    localparam int STARVE  = (NUM_CH - 1) * 7;

    logic               clk;
    logic               reset_L;
    logic [NUM_CH-1:0]  req;
    logic               stall;
    logic [BURST_W-1:0] burst_len;
    logic [NUM_CH-1:0]  pop;
    logic [SEL_W-1:0]   port_mux;
    logic               valid_mux;

    rr_arbiter_n #(
        .NUM_CH  (NUM_CH),
        .SEL_W   (SEL_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .req       (req),
        .stall     (stall),
        .burst_len (burst_len),
        .pop       (pop),
        .port_mux  (port_mux),
        .valid_mux (valid_mux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [1:0] port;
    } out_t;

    out_t q_exp[$];

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    bit       m_burst;
    int       m_last, m_cnt, m_blen, m_port;
    bit       n_burst;
    int       n_last, n_cnt, n_blen;
    int       wait_cnt[NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_burst = 0; m_last = NUM_CH - 1; m_cnt = 0; m_blen = 1; m_port = 0;
        for (int i = 0; i < NUM_CH; i++) wait_cnt[i] = 0;
        q_exp.delete();
    endtask

    task automatic model_eval(output logic [NUM_CH-1:0] ep);
        bit arb;
        ep = '0;
        arb = 0;
        n_burst = m_burst; n_last = m_last; n_cnt = m_cnt; n_blen = m_blen;
        if (!stall) begin
            if (m_burst && req[m_last]) begin
                ep[m_last] = 1'b1;
                n_cnt = m_cnt + 1;
                n_burst = (n_cnt != m_blen);
            end else begin
                arb = 1;
                n_burst = 0;
            end
        end
        if (arb && req != 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (ep == 0 && req[c]) begin
                    ep[c]   = 1'b1;
                    n_last  = c;
                    n_cnt   = 1;
                    n_blen  = (burst_len == 0) ? 1 : int'(burst_len);
                    n_burst = (n_blen > 1);
                end
            end
        end
    endtask

    task automatic step(input logic [NUM_CH-1:0] dir, input bit has_dir);
        logic [NUM_CH-1:0] ep;
        out_t e;
        #1;
        model_eval(ep);
        check("pop", 32'(pop), 32'(ep));
        if (has_dir) check("pop_dir", 32'(pop), 32'(dir));
        check("onehot", 32'($countones(pop) <= 1), 32'd1);
        check("pop_legal", 32'((pop & ~(req & {NUM_CH{!stall}})) == 0), 32'd1);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!req[i] || pop[i]) wait_cnt[i] = 0;
            else if (!stall) wait_cnt[i]++;
            if (wait_cnt[i] > STARVE) check("starve", 32'(wait_cnt[i]), 32'(STARVE));
        end
        e.valid = |ep;
        for (int i = 0; i < NUM_CH; i++) if (ep[i]) m_port = i;
        e.port  = 2'(m_port);
        q_exp.push_back(e);
        @(posedge clk);
        m_burst = n_burst; m_last = n_last; m_cnt = n_cnt; m_blen = n_blen;
        #1;
        if (q_exp.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            check("valid_mux", 32'(valid_mux), 32'(e.valid));
            check("port_mux", 32'(port_mux), 32'(e.port));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_valid", 32'(valid_mux), 32'd0);
        check("rst_port", 32'(port_mux), 32'd0);
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        logic [NUM_CH-1:0] t1[5];
        logic [NUM_CH-1:0] t2[9];
        logic [NUM_CH-1:0] t3[6];
        logic [NUM_CH-1:0] t4[5];
        t1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100,
               4'b0001, 4'b0001, 4'b0001};
        t3 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        t4 = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001};

        reset_L = 1'b0; req = '0; stall = 1'b0; burst_len = 3'd1;
        @(negedge clk);
        do_reset();

        // 1: single-pop rotation
        req = 4'b1111; burst_len = 3'd1;
        for (int i = 0; i < 5; i++) step(t1[i], 1'b1);

        // 2: bursts of three, no bubbles
        do_reset();
        req = 4'b0101; burst_len = 3'd3;
        for (int i = 0; i < 9; i++) step(t2[i], 1'b1);

        // 3: owner drains mid-burst
        do_reset();
        req = 4'b0011; burst_len = 3'd4;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) req = 4'b0010;
            step(t3[i], 1'b1);
        end
        req = 4'b0000;
        step(4'b0000, 1'b1);

        // 4: stall inside a burst
        do_reset();
        req = 4'b0001; burst_len = 3'd3;
        for (int i = 0; i < 5; i++) begin
            stall = (i == 1 || i == 2);
            step(t4[i], 1'b1);
        end
        stall = 1'b0;

        // 5: reset mid-burst, then burst_len=0
        do_reset();
        req = 4'b0001; burst_len = 3'd3;
        step(4'b0001, 1'b1);
        do_reset();
        req = 4'b1000; burst_len = 3'd0;
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b1);

        // 6: random traffic
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < NUM_CH; b++)
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            stall     = ($urandom_range(0, 7) == 0);
            burst_len = 3'($urandom_range(0, 7));
            step(4'b0000, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
